jt89_interp: RTL and testbench
==============================

Name: jt89_interp

Overview:
- Parametrised multi-channel CIC interpolation filter for JT89-family PSG outputs.
- Takes low-rate signed samples per channel and produces a smoothed stream at the output-rate clock enable, with a factor of 2^LOG2R and order STAGES.
- Sits between PSG cores (one or more, e.g. stereo or dual-chip systems) and the system audio mixer. Replaces the fixed x16 interpolation with a configurable one.
- Adds a runtime bypass mode, which the fixed version does not have.

Parameters:
- CHANNELS, 1: number of independent audio channels, processed in parallel.
- IW, 11: input/output sample width, signed two's complement.
- LOG2R, 4: log2 of the interpolation factor R (1..6).
- STAGES, 2: CIC order N (1..4). Gives N comb stages and N integrator stages.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low. Sampled on the rising edge of clk; low = reset.
- cen  in  1  output-rate clock enable. All filter state advances only when cen=1.
- bypass  in  1  1 = sample-and-hold passthrough; 0 = CIC interpolation.
- din  in  CHANNELS*IW  packed input samples; channel k occupies [k*IW +: IW].
- din_req  out  1  one-clk pulse on the cen cycle where din is captured (phase 0).
- dout  out  CHANNELS*IW  packed interpolated output, registered.
- dout_vld  out  1  one-clk pulse, one clk after each cen, when dout has updated.

Behaviour:
- Reset (rst=0 at a clk edge) clears the phase counter, all comb delays, integrators, dout, din_req and dout_vld to 0. This holds mid-operation: no partial state survives, and the first cen after release is phase 0.
- Phase counter is LOG2R bits and increments on each cen, wrapping from R-1 to 0.
- On a cen with phase==0:
  - din is captured and din_req=1 in the same cycle.
  - The comb chain runs once. Comb stage j computes y = x - x_prev and stores x.
  - The comb output feeds integrator 1.
- On a cen with phase!=0, integrator 1 input is 0 (zero stuffing).
- Integrators update on every cen, in a pipelined chain: integrator i adds integrator i-1's previous registered value.
- Internal width is W = IW + STAGES*LOG2R. All comb and integrator arithmetic wraps modulo 2^W; no saturation is applied internally.
- Output scaling: dout = integrator N >> ((STAGES-1)*LOG2R), arithmetic shift, truncated to IW bits. DC gain is exactly 1.
- Latency: a step captured at phase 0 starts changing dout STAGES cen pulses later. dout is registered and updates the clk after cen.
- Bypass=1:
  - dout takes the din captured at phase 0, held for R cen pulses.
  - The phase counter keeps running.
  - Comb and integrator state are cleared each cen, so returning to 0 restarts the filter from zero state without a wrap glitch.
- A bypass change takes effect at the next cen.
- cen=0: all state, dout and the phase counter hold; dout_vld=0.
- Back-to-back cen on every clk is legal and gives full throughput.
- Channels are fully independent and share only phase, din_req and dout_vld.

Decomposition:
- Small shared package jt89_interp_pkg holds:
  - the width function W(IW, LOG2R, STAGES);
  - the shift constant;
  - parameter-range checks, which raise an elaboration error outside 1..6 / 1..4.
- One natural sub-module, jt89_interp_ch: a single-channel comb/integrator datapath.
  - It is generated CHANNELS times.
  - Phase and strobes are kept in the top level.

Test Plan:
1. LOG2R=2, STAGES=2, cen every clk, step din 0 -> 1000 at phase 0 -> dout sequence 0,0,250,500,750,1000,1000,... (ramp begins 2 cen after capture); din_req every 4th cen.
2. Defaults, constant din = -1024 (full negative) for 64 cen -> dout settles to exactly -1024 with no wrap; then +1023 -> settles to +1023.
3. Reset asserted low mid-ramp from test 1 -> next clk dout=0, dout_vld=0; after release the first cen is phase 0 (din_req=1) and the ramp restarts from 0.
4. bypass=1, din alternating 300/-300 each capture -> dout holds 300 for 4 cen, then -300 for 4 cen, with no intermediate values; toggle bypass=0 -> filtered ramp from 0 with no glitch.
5. cen asserted 1 clk in 3 -> results identical to test 1 per cen; dout and phase unchanged on non-cen clks; dout_vld only after cen.
6. CHANNELS=2: ch0 step to 1000, ch1 held at -500 -> ch0 ramps as in test 1; ch1 converges to -500, unaffected by ch0.

Source files
------------

// File: rtl/jt89_interp_pkg.sv
// Shared sizing helpers and parameter-range rules for the JT89 CIC interpolator.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package jt89_interp_pkg;

    localparam int LOG2R_MIN  = 1;
    localparam int LOG2R_MAX  = 6;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    // Internal accumulator width: enough headroom for the R^(N-1) gain plus comb growth.
    function automatic int cic_w(input int iw, input int log2r, input int stages);
        return iw + stages * log2r;
    endfunction

    // Right shift that removes the R^(N-1) DC gain of an interpolating CIC.
    function automatic int cic_shift(input int log2r, input int stages);
        return (stages - 1) * log2r;
    endfunction

    // True when the filter geometry is inside the supported range.
    function automatic bit params_ok(input int log2r, input int stages);
        return (log2r >= LOG2R_MIN) && (log2r <= LOG2R_MAX) &&
               (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/jt89_interp_if.sv
// Sample bus between the PSG side, the interpolator and the audio mixer.
// Latency: n/a (wiring only).
// Backpressure: none; cen paces the bus, din_req asks for the next low-rate sample.
interface jt89_interp_if #(
    parameter int CHANNELS = 1,
    parameter int IW       = 11
);
    logic                   cen;
    logic                   bypass;
    logic [CHANNELS*IW-1:0] din;
    logic                   din_req;
    logic [CHANNELS*IW-1:0] dout;
    logic                   dout_vld;

    modport master (
        output cen, bypass, din,
        input  din_req, dout, dout_vld
    );

    modport slave (
        input  cen, bypass, din,
        output din_req, dout, dout_vld
    );
endinterface

// File: rtl/jt89_interp_ch.sv
// One channel of the CIC interpolator: comb chain at the low rate, integrators at the cen rate.
// Latency: a step captured at phase 0 reaches dout STAGES cen pulses later; dout is registered.
// Backpressure: none; all state advances only on cen_i.
module jt89_interp_ch
    import jt89_interp_pkg::*;
#(
    parameter int IW     = 11,
    parameter int LOG2R  = 4,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen_i,
    input  logic          bypass_i,
    input  logic          ph0_i,
    input  logic [IW-1:0] din_i,
    output logic [IW-1:0] dout_o
);
    localparam int W  = cic_w(IW, LOG2R, STAGES);
    localparam int SH = cic_shift(LOG2R, STAGES);

    logic signed [W-1:0] comb_x [STAGES];   // input seen by each comb stage this cycle
    logic signed [W-1:0] comb_acc;
    logic signed [W-1:0] integ_in;
    logic signed [W-1:0] cdly_q  [STAGES];
    logic signed [W-1:0] cdly_d  [STAGES];
    logic signed [W-1:0] integ_q [STAGES];
    logic signed [W-1:0] integ_d [STAGES];
    logic [IW-1:0]       hold_q, hold_d;
    logic [IW-1:0]       dout_q, dout_d;

    // Comb chain on the sign-extended input; its result is only used on phase 0 (zero stuffing otherwise).
    always_comb begin
        comb_acc = W'($signed(din_i));
        for (int j = 0; j < STAGES; j++) begin
            comb_x[j] = comb_acc;
            comb_acc  = comb_acc - cdly_q[j];
        end
        integ_in = ph0_i ? comb_acc : '0;
    end

    // Next-state for delays, integrators, held sample and output.
    always_comb begin
        cdly_d  = cdly_q;
        integ_d = integ_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        if (cen_i) begin
            if (ph0_i) begin
                hold_d = din_i;
            end
            if (bypass_i) begin
                // Keep the filter at zero state so leaving bypass cannot produce a wrap glitch.
                for (int j = 0; j < STAGES; j++) begin
                    cdly_d[j]  = '0;
                    integ_d[j] = '0;
                end
                dout_d = ph0_i ? din_i : hold_q;
            end else begin
                if (ph0_i) begin
                    cdly_d = comb_x;
                end
                // Pipelined integrators: each stage adds the previous stage's registered value.
                integ_d[0] = integ_q[0] + integ_in;
                for (int i = 1; i < STAGES; i++) begin
                    integ_d[i] = integ_q[i] + integ_q[i-1];
                end
                dout_d = IW'(integ_q[STAGES-1] >>> SH);
            end
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < STAGES; j++) begin
                cdly_q[j]  <= '0;
                integ_q[j] <= '0;
            end
            hold_q <= '0;
            dout_q <= '0;
        end else begin
            cdly_q  <= cdly_d;
            integ_q <= integ_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/jt89_interp.sv
// Multi-channel CIC interpolator (factor 2^LOG2R, order STAGES) with sample-and-hold bypass.
// Latency: dout registered one clk after cen; a phase-0 step starts moving dout STAGES cen later.
// Backpressure: none; cen paces everything, din_req pulses when din is captured.
module jt89_interp
    import jt89_interp_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int IW       = 11,
    parameter int LOG2R    = 4,
    parameter int STAGES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    jt89_interp_if.slave  bus
);
    if (!params_ok(LOG2R, STAGES)) begin : g_bad_params
        $error("jt89_interp: LOG2R must be 1..6 and STAGES must be 1..4");
    end

    logic [LOG2R-1:0] phase_q, phase_d;
    logic             vld_q, vld_d;
    logic             ph0;

    assign ph0 = (phase_q == '0);

    // Phase advances once per cen and wraps naturally at R; dout_vld follows every cen.
    always_comb begin
        phase_d = phase_q;
        vld_d   = 1'b0;
        if (bus.cen) begin
            phase_d = phase_q + LOG2R'(1);
            vld_d   = 1'b1;
        end
    end

    // Shared phase and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            vld_q   <= vld_d;
        end
    end

    // Request is suppressed while reset is held so no capture is advertised that will not happen.
    assign bus.din_req  = rst & bus.cen & ph0;
    assign bus.dout_vld = vld_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        jt89_interp_ch #(
            .IW     (IW),
            .LOG2R  (LOG2R),
            .STAGES (STAGES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .cen_i    (bus.cen),
            .bypass_i (bus.bypass),
            .ph0_i    (ph0),
            .din_i    (bus.din[k*IW +: IW]),
            .dout_o   (bus.dout[k*IW +: IW])
        );
    end

endmodule

// File: tb/tb_jt89_interp.sv
// Directed bench for jt89_interp: a 2-channel R=4 N=2 instance and a default-parameter instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_jt89_interp;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    jt89_interp_if #(.CHANNELS(2), .IW(11)) a_if ();
    jt89_interp_if #(.CHANNELS(1), .IW(11)) b_if ();

    jt89_interp #(.CHANNELS(2), .IW(11), .LOG2R(2), .STAGES(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    jt89_interp #(.CHANNELS(1), .IW(11), .LOG2R(4), .STAGES(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int errors = 0;
    int checks = 0;

    logic signed [10:0] o0, o1, ob;
    logic               vld, vldb;

    // Hand-derived R=4, N=2 response to a 0 -> 1000 step captured at cen 0.
    int step_exp [10] = '{0, 0, 250, 500, 750, 1000, 1000, 1000, 1000, 1000};
    // Same filter, 0 -> 300 step.
    int byp_exp  [6]  = '{0, 0, 75, 150, 225, 300};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst         = 1'b0;
        a_if.cen    = 1'b0;
        a_if.bypass = 1'b0;
        b_if.cen    = 1'b0;
        b_if.bypass = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive one clk on instance A (starting at a negedge); outputs sampled at the following negedge.
    task automatic cyc_a(input logic c, input logic byp, input logic signed [10:0] d0,
                         input logic signed [10:0] d1, output logic req);
        a_if.cen    = c;
        a_if.bypass = byp;
        a_if.din    = {d1, d0};
        #1 req = a_if.din_req;
        @(negedge clk);
        o0  = a_if.dout[10:0];
        o1  = a_if.dout[21:11];
        vld = a_if.dout_vld;
    endtask

    task automatic cyc_b(input logic c, input logic signed [10:0] d, output logic req);
        b_if.cen    = c;
        b_if.bypass = 1'b0;
        b_if.din    = d;
        #1 req = b_if.din_req;
        @(negedge clk);
        ob   = b_if.dout;
        vldb = b_if.dout_vld;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        a_if.cen    = 1'b1;
        a_if.bypass = 1'b0;
        a_if.din    = {11'sd500, 11'sd500};
        b_if.cen    = 1'b1;
        b_if.bypass = 1'b0;
        b_if.din    = 11'sd500;
        #1;
        checks++;
        if (a_if.din_req !== 1'b0) begin
            errors++; $display("FAIL reset_din_req_a got %0b want 0", a_if.din_req);
        end
        checks++;
        if (b_if.din_req !== 1'b0) begin
            errors++; $display("FAIL reset_din_req_b got %0b want 0", b_if.din_req);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (a_if.dout !== 22'd0) begin
            errors++; $display("FAIL reset_dout_a got %h want 0", a_if.dout);
        end
        checks++;
        if (a_if.dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld_a got %0b want 0", a_if.dout_vld);
        end
        checks++;
        if (b_if.dout !== 11'd0) begin
            errors++; $display("FAIL reset_dout_b got %h want 0", b_if.dout);
        end
        checks++;
        if (b_if.dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld_b got %0b want 0", b_if.dout_vld);
        end
        a_if.cen = 1'b0;
        b_if.cen = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step();
        logic req;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cyc_a(1'b1, 1'b0, 11'sd1000, 11'sd0, req);
            checks++;
            if (req !== (n % 4 == 0)) begin
                errors++; $display("FAIL step_din_req n=%0d got %0b want %0b", n, req, (n % 4 == 0));
            end
            checks++;
            if (o0 !== 11'(step_exp[n])) begin
                errors++; $display("FAIL step_dout n=%0d got %0d want %0d", n, o0, step_exp[n]);
            end
            checks++;
            if (vld !== 1'b1) begin
                errors++; $display("FAIL step_vld n=%0d got %0b want 1", n, vld);
            end
        end
        a_if.cen = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic req;
        do_reset();
        for (int n = 0; n < 3; n++) cyc_a(1'b1, 1'b0, 11'sd1000, 11'sd0, req);
        checks++;
        if (o0 !== 11'sd250) begin
            errors++; $display("FAIL midreset_pre got %0d want 250", o0);
        end
        rst = 1'b0;
        cyc_a(1'b1, 1'b0, 11'sd1000, 11'sd0, req);
        rst = 1'b1;
        checks++;
        if (req !== 1'b0) begin
            errors++; $display("FAIL midreset_req got %0b want 0", req);
        end
        checks++;
        if (o0 !== 11'sd0) begin
            errors++; $display("FAIL midreset_dout got %0d want 0", o0);
        end
        checks++;
        if (vld !== 1'b0) begin
            errors++; $display("FAIL midreset_vld got %0b want 0", vld);
        end
        for (int n = 0; n < 6; n++) begin
            cyc_a(1'b1, 1'b0, 11'sd1000, 11'sd0, req);
            checks++;
            if (req !== (n % 4 == 0)) begin
                errors++; $display("FAIL midreset_restart_req n=%0d got %0b want %0b", n, req, (n % 4 == 0));
            end
            checks++;
            if (o0 !== 11'(step_exp[n])) begin
                errors++; $display("FAIL midreset_restart_dout n=%0d got %0d want %0d", n, o0, step_exp[n]);
            end
        end
        a_if.cen = 1'b0;
    endtask

    task automatic test_bypass();
        logic               req;
        logic signed [10:0] d;
        logic signed [10:0] want;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n % 4 == 0) d = ((n / 4) % 2 == 0) ? 11'sd300 : -11'sd300;
            else            d = 11'sd777;
            want = (n < 4) ? 11'sd300 : -11'sd300;
            cyc_a(1'b1, 1'b1, d, 11'sd0, req);
            checks++;
            if (o0 !== want) begin
                errors++; $display("FAIL bypass_hold n=%0d got %0d want %0d", n, o0, want);
            end
        end
        for (int n = 0; n < 6; n++) begin
            cyc_a(1'b1, 1'b0, 11'sd300, 11'sd0, req);
            if (n == 0) begin
                checks++;
                if (req !== 1'b1) begin
                    errors++; $display("FAIL bypass_exit_req got %0b want 1", req);
                end
            end
            checks++;
            if (o0 !== 11'(byp_exp[n])) begin
                errors++; $display("FAIL bypass_exit_ramp n=%0d got %0d want %0d", n, o0, byp_exp[n]);
            end
        end
        a_if.cen = 1'b0;
    endtask

    task automatic test_cen_gap();
        logic               req;
        logic               c;
        logic signed [10:0] prev;
        int                 n;
        do_reset();
        n    = 0;
        prev = 11'sd0;
        for (int k = 0; k < 24; k++) begin
            c = (k % 3 == 0);
            cyc_a(c, 1'b0, 11'sd1000, 11'sd0, req);
            if (c) begin
                checks++;
                if (req !== (n % 4 == 0)) begin
                    errors++; $display("FAIL gap_req n=%0d got %0b want %0b", n, req, (n % 4 == 0));
                end
                checks++;
                if (o0 !== 11'(step_exp[n])) begin
                    errors++; $display("FAIL gap_dout n=%0d got %0d want %0d", n, o0, step_exp[n]);
                end
                checks++;
                if (vld !== 1'b1) begin
                    errors++; $display("FAIL gap_vld_on n=%0d got %0b want 1", n, vld);
                end
                n++;
            end else begin
                checks++;
                if (o0 !== prev) begin
                    errors++; $display("FAIL gap_hold k=%0d got %0d want %0d", k, o0, prev);
                end
                checks++;
                if (vld !== 1'b0) begin
                    errors++; $display("FAIL gap_vld_off k=%0d got %0b want 0", k, vld);
                end
                checks++;
                if (req !== 1'b0) begin
                    errors++; $display("FAIL gap_req_off k=%0d got %0b want 0", k, req);
                end
            end
            prev = o0;
        end
        a_if.cen = 1'b0;
    endtask

    task automatic test_channels();
        logic req;
        int   want1;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cyc_a(1'b1, 1'b0, 11'sd1000, -11'sd500, req);
            want1 = -step_exp[n] / 2;
            checks++;
            if (o0 !== 11'(step_exp[n])) begin
                errors++; $display("FAIL chan0 n=%0d got %0d want %0d", n, o0, step_exp[n]);
            end
            checks++;
            if (o1 !== 11'(want1)) begin
                errors++; $display("FAIL chan1 n=%0d got %0d want %0d", n, o1, want1);
            end
        end
        a_if.cen = 1'b0;
    endtask

    task automatic test_fullscale();
        logic               req;
        logic               mono;
        logic signed [10:0] prev;
        logic signed [10:0] neg_full;
        neg_full = 11'h400;
        do_reset();
        mono = 1'b1;
        prev = 11'sd0;
        for (int n = 0; n < 64; n++) begin
            cyc_b(1'b1, neg_full, req);
            if (n == 0 || n == 15 || n == 16) begin
                checks++;
                if (req !== (n % 16 == 0)) begin
                    errors++; $display("FAIL full_req n=%0d got %0b want %0b", n, req, (n % 16 == 0));
                end
            end
            if (ob > prev) mono = 1'b0;
            prev = ob;
        end
        checks++;
        if (ob !== neg_full) begin
            errors++; $display("FAIL full_neg_settle got %0d want -1024", ob);
        end
        checks++;
        if (mono !== 1'b1) begin
            errors++; $display("FAIL full_neg_monotone got %0b want 1", mono);
        end
        for (int n = 0; n < 64; n++) begin
            cyc_b(1'b1, 11'sd1023, req);
            if (ob < prev) mono = 1'b0;
            prev = ob;
        end
        checks++;
        if (ob !== 11'sd1023) begin
            errors++; $display("FAIL full_pos_settle got %0d want 1023", ob);
        end
        checks++;
        if (mono !== 1'b1) begin
            errors++; $display("FAIL full_pos_monotone got %0b want 1", mono);
        end
        checks++;
        if (vldb !== 1'b1) begin
            errors++; $display("FAIL full_vld got %0b want 1", vldb);
        end
        b_if.cen = 1'b0;
    endtask

    initial begin
        a_if.cen    = 1'b0;
        a_if.bypass = 1'b0;
        a_if.din    = '0;
        b_if.cen    = 1'b0;
        b_if.bypass = 1'b0;
        b_if.din    = '0;
        @(negedge clk);
        test_reset();
        test_step();
        test_reset_mid();
        test_bypass();
        test_cen_gap();
        test_channels();
        test_fullscale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
